// File: rtl/ft_bus_arbiter_if.sv
// FT245 sync-FIFO bus arbiter signal bundle: request inputs, bus-control outputs and status.
// slave = arbiter side, master = pin logic / FIFO side.
interface ft_bus_arbiter_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 rx_avail;
  logic                 rx_fifo_ready;
  logic                 tx_space;
  logic                 tx_pending;
  logic                 rx_oe;
  logic                 tx_drive;
  logic                 rx_xfer_en;
  logic                 tx_xfer_en;
  logic                 rx_active;
  logic                 tx_active;
  logic                 busy;
  logic [CNT_WIDTH-1:0] burst_count;
  logic                 siwu_pulse;

  modport slave (
    input  rx_avail, rx_fifo_ready, tx_space, tx_pending,
    output rx_oe, tx_drive, rx_xfer_en, tx_xfer_en,
           rx_active, tx_active, busy, burst_count, siwu_pulse
  );

  modport master (
    output rx_avail, rx_fifo_ready, tx_space, tx_pending,
    input  rx_oe, tx_drive, rx_xfer_en, tx_xfer_en,
           rx_active, tx_active, busy, burst_count, siwu_pulse
  );
endinterface

// File: rtl/ft_bus_arbiter.sv
// Half-duplex FT245 bus arbiter: round-robin RX/TX grants, bounded bursts, OE lead and turnaround.
// Optional send-immediate pulse built only when FT_ARB_SIWU_EN is defined.
module ft_bus_arbiter #(
  parameter int MAX_RX_BURST = 64,
  parameter int MAX_TX_BURST = 64,
  parameter int TURN_CYCLES  = 1,
  parameter int CNT_WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  ft_bus_arbiter_if.slave  bus
);
  localparam int TURN_W    = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int TURN_LAST = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

  typedef enum logic [2:0] {S_IDLE, S_RX_OE, S_RX_XFER, S_TX_XFER, S_TURN} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_last_tx;
  logic [CNT_WIDTH-1:0] r_burst_count;
  logic [TURN_W-1:0]    r_turn_cnt;
  logic                 r_rx_oe, r_tx_drive;

  logic w_rx_req, w_tx_req, w_grant_rx, w_grant_tx;
  logic w_rx_beat, w_tx_beat, w_rx_exit, w_tx_exit;
  state_t w_after;

  assign w_rx_req  = bus.rx_avail & bus.rx_fifo_ready;
  assign w_tx_req  = bus.tx_pending & bus.tx_space;
  assign w_rx_beat = (r_state == S_RX_XFER) & w_rx_req;
  assign w_tx_beat = (r_state == S_TX_XFER) & w_tx_req;
  assign w_rx_exit = (r_state == S_RX_XFER) &
                     (~w_rx_req | (r_burst_count == CNT_WIDTH'(MAX_RX_BURST - 1)));
  assign w_tx_exit = (r_state == S_TX_XFER) &
                     (~w_tx_req | (r_burst_count == CNT_WIDTH'(MAX_TX_BURST - 1)));
  // On a tie the direction not served last wins; last_dir resets to TX so RX wins first.
  assign w_grant_rx = (r_state == S_IDLE) & w_rx_req & (~w_tx_req | r_last_tx);
  assign w_grant_tx = (r_state == S_IDLE) & w_tx_req & (~w_rx_req | ~r_last_tx);
  assign w_after    = (TURN_CYCLES == 0) ? S_IDLE : S_TURN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_grant_rx) w_state_nxt = S_RX_OE;
                 else if (w_grant_tx) w_state_nxt = S_TX_XFER;
      S_RX_OE:   w_state_nxt = S_RX_XFER;
      S_RX_XFER: if (w_rx_exit) w_state_nxt = w_after;
      S_TX_XFER: if (w_tx_exit) w_state_nxt = w_after;
      S_TURN:    if (r_turn_cnt == TURN_W'(TURN_LAST)) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_tx     <= 1'b1;
      r_burst_count <= '0;
      r_turn_cnt    <= '0;
      r_rx_oe       <= 1'b0;
      r_tx_drive    <= 1'b0;
    end else begin
      if (w_grant_rx) begin
        r_last_tx     <= 1'b0;
        r_burst_count <= '0;
        r_rx_oe       <= 1'b1;
      end else if (w_grant_tx) begin
        r_last_tx     <= 1'b1;
        r_burst_count <= '0;
        r_tx_drive    <= 1'b1;
      end
      if (w_rx_beat | w_tx_beat) r_burst_count <= r_burst_count + 1'b1;
      if (w_rx_exit) r_rx_oe    <= 1'b0;
      if (w_tx_exit) r_tx_drive <= 1'b0;
      // Held at zero outside TURN so every gap starts counting fresh.
      if (r_state != S_TURN) r_turn_cnt <= '0;
      else if (r_turn_cnt != TURN_W'(TURN_LAST)) r_turn_cnt <= r_turn_cnt + 1'b1;
    end
  end

  assign bus.rx_oe       = r_rx_oe;
  assign bus.tx_drive    = r_tx_drive;
  assign bus.rx_xfer_en  = w_rx_beat;
  assign bus.tx_xfer_en  = w_tx_beat;
  assign bus.rx_active   = (r_state == S_RX_OE) | (r_state == S_RX_XFER);
  assign bus.tx_active   = (r_state == S_TX_XFER);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.burst_count = r_burst_count;

`ifdef FT_ARB_SIWU_EN
  // Flush a short packet when TX ran dry, not when it merely hit the burst limit.
  logic r_siwu;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_siwu <= 1'b0;
    else     r_siwu <= w_tx_exit & ~bus.tx_pending;
  end
  assign bus.siwu_pulse = r_siwu;
`else
  assign bus.siwu_pulse = 1'b0;
`endif
endmodule
